mem_req_arbiter: RTL and testbench

Sits directly upstream of the unified memory model. It arbitrates dcache and icache requests onto the single proc2mem bus and passes the memory's accept tag back to the winning client. It keeps an owner table indexed by memory tag and routes each tagged load return (mem2proc_tag/data) to the client that issued it, registered by one cycle.

---
 rtl/mem_req_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_req_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Arbitrates dcache and icache requests onto the single proc2mem bus and
//   routes tagged load returns back to the client that issued them.
//
//   Grant is combinational. By default dcache has fixed priority over icache.
//   If ARB_ROUND_ROBIN_EN is defined, a last_winner register gives priority
//   to whichever client did not win the last accepted grant.
//
//   An owner table indexed by memory tag (1..NUM_TAGS) remembers who issued
//   each accepted load. A tagged return is registered onto that client's
//   arb2*_tag/data one cycle later. Returns for tags with no valid entry are
//   dropped.
//
// Ports
//   clock, reset              : clock; asynchronous active-high reset
//   dcache2arb_command/addr/data, icache2arb_command/addr : client requests
//   proc2mem_command/addr/data : granted request to memory (combinational)
//   mem2proc_response          : memory accept tag (0 = rejected)
//   mem2proc_tag/data          : returning load tag (0 = none) and data
//   arb2dcache_response, arb2icache_response : accept tag to the winner
//   arb2dcache_tag/data, arb2icache_tag/data : registered load returns
//   arb_outstanding            : number of valid owner-table entries
module mem_req_arbiter #(
    parameter int NUM_TAGS = 15,
    parameter int TAG_W    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       dcache2arb_command,
    input  logic [63:0]      dcache2arb_addr,
    input  logic [63:0]      dcache2arb_data,
    input  logic [1:0]       icache2arb_command,
    input  logic [63:0]      icache2arb_addr,
    output logic [1:0]       proc2mem_command,
    output logic [63:0]      proc2mem_addr,
    output logic [63:0]      proc2mem_data,
    input  logic [TAG_W-1:0] mem2proc_response,
    input  logic [TAG_W-1:0] mem2proc_tag,
    input  logic [63:0]      mem2proc_data,
    output logic [TAG_W-1:0] arb2dcache_response,
    output logic [TAG_W-1:0] arb2icache_response,
    output logic [TAG_W-1:0] arb2dcache_tag,
    output logic [63:0]      arb2dcache_data,
    output logic [TAG_W-1:0] arb2icache_tag,
    output logic [63:0]      arb2icache_data,
    output logic [4:0]       arb_outstanding
);

    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    // ---------------- grant ----------------
    logic dc_req, ic_req, grant_dc, grant_ic;

    assign dc_req = (dcache2arb_command != BUS_NONE);
    // icache never stores; a STORE from it is treated as no request
    assign ic_req = (icache2arb_command == BUS_LOAD);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_winner;  // 1 = icache won the last accepted grant

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            last_winner <= 1'b1;
        else if (mem2proc_response != '0 && (grant_dc || grant_ic))
            last_winner <= grant_ic;
    end

    assign grant_dc = dc_req && (!ic_req || last_winner);
`else
    assign grant_dc = dc_req;
`endif
    assign grant_ic = ic_req && !grant_dc;

    always_comb begin
        proc2mem_command    = BUS_NONE;
        proc2mem_addr       = '0;
        proc2mem_data       = '0;
        arb2dcache_response = '0;
        arb2icache_response = '0;
        if (grant_dc) begin
            proc2mem_command    = dcache2arb_command;
            proc2mem_addr       = dcache2arb_addr;
            proc2mem_data       = dcache2arb_data;
            arb2dcache_response = mem2proc_response;
        end else if (grant_ic) begin
            proc2mem_command    = icache2arb_command;
            proc2mem_addr       = icache2arb_addr;
            arb2icache_response = mem2proc_response;
        end
    end

    // ---------------- owner table ----------------
    // Bit 0 is never set: tag 0 means none/rejected.
    logic [NUM_TAGS:0] valid_q, owner_q;  // owner: 1 = icache
    logic [NUM_TAGS:0] valid_d, owner_d;
    logic              alloc, rel, rel_owner;

    assign alloc = (mem2proc_response != '0) &&
                   (int'(mem2proc_response) <= NUM_TAGS) &&
                   (proc2mem_command == BUS_LOAD);

    assign rel       = (mem2proc_tag != '0) &&
                       (int'(mem2proc_tag) <= NUM_TAGS) &&
                       valid_q[mem2proc_tag];
    assign rel_owner = owner_q[mem2proc_tag];

    // Release first so a same-cycle reuse of the tag leaves it valid with
    // the new owner. Overwriting a valid entry keeps the popcount honest.
    always_comb begin
        valid_d = valid_q;
        owner_d = owner_q;
        if (rel)
            valid_d[mem2proc_tag] = 1'b0;
        if (alloc) begin
            valid_d[mem2proc_response] = 1'b1;
            owner_d[mem2proc_response] = grant_ic;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q         <= '0;
            owner_q         <= '0;
            arb_outstanding <= '0;
        end else begin
            valid_q         <= valid_d;
            owner_q         <= owner_d;
            arb_outstanding <= 5'($countones(valid_d));
        end
    end

    // ---------------- return routing ----------------
    // Tags are one-cycle pulses; data holds when no return is routed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            arb2dcache_tag  <= '0;
            arb2dcache_data <= '0;
            arb2icache_tag  <= '0;
            arb2icache_data <= '0;
        end else begin
            arb2dcache_tag <= '0;
            arb2icache_tag <= '0;
            if (rel && !rel_owner) begin
                arb2dcache_tag  <= mem2proc_tag;
                arb2dcache_data <= mem2proc_data;
            end
            if (rel && rel_owner) begin
                arb2icache_tag  <= mem2proc_tag;
                arb2icache_data <= mem2proc_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter with a tag-ownership reference model.
module tb_mem_req_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  dcache2arb_command, icache2arb_command;
    logic [63:0] dcache2arb_addr, dcache2arb_data, icache2arb_addr;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr, proc2mem_data;
    logic [3:0]  mem2proc_response, mem2proc_tag;
    logic [63:0] mem2proc_data;
    logic [3:0]  arb2dcache_response, arb2icache_response;
    logic [3:0]  arb2dcache_tag, arb2icache_tag;
    logic [63:0] arb2dcache_data, arb2icache_data;
    logic [4:0]  arb_outstanding;

    mem_req_arbiter #(.NUM_TAGS(15), .TAG_W(4)) dut (
        .clock(clock), .reset(reset),
        .dcache2arb_command(dcache2arb_command), .dcache2arb_addr(dcache2arb_addr),
        .dcache2arb_data(dcache2arb_data),
        .icache2arb_command(icache2arb_command), .icache2arb_addr(icache2arb_addr),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data),
        .mem2proc_response(mem2proc_response), .mem2proc_tag(mem2proc_tag),
        .mem2proc_data(mem2proc_data),
        .arb2dcache_response(arb2dcache_response), .arb2icache_response(arb2icache_response),
        .arb2dcache_tag(arb2dcache_tag), .arb2dcache_data(arb2dcache_data),
        .arb2icache_tag(arb2icache_tag), .arb2icache_data(arb2icache_data),
        .arb_outstanding(arb_outstanding)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns each tag (-1 = nobody), who won last.
    int          own_m[16];
    int          last_m;            // 0 = dcache, 1 = icache
    logic [3:0]  exp_dtag, exp_itag;
    logic [63:0] exp_ddata, exp_idata;

    function automatic int count_owned();
        int n = 0;
        for (int k = 1; k < 16; k++) if (own_m[k] >= 0) n++;
        return n;
    endfunction

    // One clock cycle. Entered and left at posedge+1.
    task automatic cyc(input logic [1:0] dc, input logic [63:0] da, input logic [63:0] dd,
                       input logic [1:0] ic, input logic [63:0] ia,
                       input logic [3:0] resp, input logic [3:0] rtag,
                       input logic [63:0] rdata, input logic rst);
        int win;
        logic [1:0]  e_cmd;
        logic [63:0] e_addr, e_data;
        // registered outputs from the previous cycle
        chk("dtag", arb2dcache_tag, exp_dtag);
        chk("itag", arb2icache_tag, exp_itag);
        if (exp_dtag != 0) chk("ddata", arb2dcache_data, exp_ddata);
        if (exp_itag != 0) chk("idata", arb2icache_data, exp_idata);
        chk("outstanding", arb_outstanding, 5'(count_owned()));

        dcache2arb_command = dc; dcache2arb_addr = da; dcache2arb_data = dd;
        icache2arb_command = ic; icache2arb_addr = ia;
        mem2proc_response = resp; mem2proc_tag = rtag; mem2proc_data = rdata;
        reset = rst;
        if (rst) begin
            for (int k = 0; k < 16; k++) own_m[k] = -1;
            last_m = 1;
        end
        #1;
        if (rst) chk("rst_async", arb_outstanding, 5'd0);

        // grant
        win = -1;
        if (dc != 0 && ic == 1) begin
`ifdef ARB_ROUND_ROBIN_EN
            win = (last_m == 1) ? 0 : 1;
`else
            win = 0;
`endif
        end else if (dc != 0) win = 0;
        else if (ic == 1)     win = 1;
        e_cmd = 0; e_addr = 0; e_data = 0;
        if (win == 0) begin e_cmd = dc; e_addr = da; e_data = dd; end
        if (win == 1) begin e_cmd = ic; e_addr = ia; end
        chk("cmd",   proc2mem_command, e_cmd);
        chk("addr",  proc2mem_addr,    e_addr);
        chk("data",  proc2mem_data,    e_data);
        chk("dresp", arb2dcache_response, (win == 0) ? resp : 4'd0);
        chk("iresp", arb2icache_response, (win == 1) ? resp : 4'd0);

        // state update at the coming edge
        exp_dtag = 0; exp_itag = 0;
        if (!rst) begin
            if (rtag != 0 && own_m[rtag] >= 0) begin
                if (own_m[rtag] == 0) begin exp_dtag = rtag; exp_ddata = rdata; end
                else                  begin exp_itag = rtag; exp_idata = rdata; end
                own_m[rtag] = -1;
            end
            if (resp != 0 && win >= 0 && e_cmd == 1) own_m[resp] = win;
            if (resp != 0 && win >= 0) last_m = win;
        end
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) own_m[k] = -1;
        last_m = 1; exp_dtag = 0; exp_itag = 0; exp_ddata = 0; exp_idata = 0;
        reset = 1'b1;
        dcache2arb_command = 0; dcache2arb_addr = 0; dcache2arb_data = 0;
        icache2arb_command = 0; icache2arb_addr = 0;
        mem2proc_response = 0; mem2proc_tag = 0; mem2proc_data = 0;
        @(posedge clock); #1;

        // reset, then idle
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        chk("rst_cmd", proc2mem_command, 2'd0);
        chk("rst_out", arb_outstanding, 5'd0);
        chk("rst_dtag", arb2dcache_tag, 4'd0);

        // dcache load, tag 3, return 10 cycles later
        cyc(1, 64'h100, 0, 0, 0, 4'd3, 0, 0, 0);
        chk("ld_out1", arb_outstanding, 5'd1);
        idle(9);
        cyc(0, 0, 0, 0, 0, 0, 4'd3, 64'hDEAD, 0);
        chk("ld_dtag", arb2dcache_tag, 4'd3);
        chk("ld_ddata", arb2dcache_data, 64'hDEAD);
        chk("ld_itag", arb2icache_tag, 4'd0);
        chk("ld_out0", arb_outstanding, 5'd0);

        // store vs icache load collision, icache retries
        cyc(2, 64'h200, 64'h55, 1, 64'h300, 4'd1, 0, 0, 0);
        cyc(0, 0, 0, 1, 64'h300, 4'd2, 0, 0, 0);
        idle(2);
        cyc(0, 0, 0, 0, 0, 0, 4'd2, 64'hBEEF, 0);
        idle(1);

        // icache load tag 5, reset, stray return
        cyc(0, 0, 0, 1, 64'h500, 4'd5, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        cyc(0, 0, 0, 0, 0, 0, 4'd5, 64'h1234, 0);
        chk("stray_dtag", arb2dcache_tag, 4'd0);
        chk("stray_itag", arb2icache_tag, 4'd0);
        chk("stray_out", arb_outstanding, 5'd0);

        // tag 4 released to dcache while reallocated to icache
        cyc(1, 64'h400, 0, 0, 0, 4'd4, 0, 0, 0);
        cyc(0, 0, 0, 1, 64'h440, 4'd4, 4'd4, 64'hCAFE, 0);
        chk("swap_dtag", arb2dcache_tag, 4'd4);
        chk("swap_out", arb_outstanding, 5'd1);
        cyc(0, 0, 0, 0, 0, 0, 4'd4, 64'hF00D, 0);
        chk("swap_itag", arb2icache_tag, 4'd4);
        idle(1);

        // both clients loading continuously, memory always accepts
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++)
            cyc(1, 64'h1000 + 64'(k), 0, 1, 64'h2000 + 64'(k),
                4'(k + 1), 4'(k > 0 ? k : 0), 64'(k), 0);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            logic [3:0] r, t;
            r = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            t = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            cyc(2'($urandom_range(0, 2)), {$urandom, $urandom}, {$urandom, $urandom},
                2'($urandom_range(0, 2)), {$urandom, $urandom},
                r, t, {$urandom, $urandom}, ($urandom_range(0, 59) == 0));
        end
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
